// File: rtl/seven_segment_scanner.sv
// Multiplexed N-digit common-anode 7-segment driver with frame snapshots,
// PWM brightness, per-digit blink and leading-zero suppression.
module seven_segment_scanner #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 65536,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   nums,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic [3:0]            brightness,
  input  logic                  lz_en,
  input  logic [1:0]            switchMode,
  output logic [6:0]            display,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     digit
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int FW = $clog2(BLINK_FRAMES) + 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [3:0]            pwm_cnt_q, pwm_cnt_d;
  logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic                  started_q, started_d;
  logic [4*DIGITS-1:0]   snap_nums_q, snap_nums_d;
  logic [DIGITS-1:0]     snap_dp_q, snap_dp_d;
  logic [DIGITS-1:0]     snap_blink_q, snap_blink_d;
  logic [6:0]            display_q, display_d;
  logic                  dp_out_q, dp_out_d;
  logic [DIGITS-1:0]     digit_q, digit_d;

  logic                  tick;
  logic                  frame_start;
  logic                  upper_zero;
  logic [DIGITS-1:0]     lz_mask;
  logic [3:0]            next_code;
  logic                  next_dp;
  logic                  next_lz;
  logic                  cur_blink;
  logic [DIGITS-1:0]     cur_strobe;
  logic                  lit;

  function automatic logic [6:0] glyph(input logic [3:0] code, input logic manual);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = manual ? 7'b0101011 : 7'b0010000;
      4'd10:   seg = 7'b1000110;
      4'd11:   seg = 7'b0111111;
      4'd12:   seg = 7'b0100001;
      4'd13:   seg = 7'b1000111;
      4'd14:   seg = 7'b0000110;
      default: seg = manual ? 7'b1111111 : 7'b0101111;
    endcase
    return seg;
  endfunction

  // Slot timing, frame snapshot and blink phase bookkeeping.
  always_comb begin
    tick          = (scan_cnt_q == SCAN_LAST);
    frame_start   = tick && (idx_q == IDX_LAST);
    scan_cnt_d    = tick ? '0 : scan_cnt_q + 1'b1;
    idx_d         = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    pwm_cnt_d     = pwm_cnt_q + 1'b1;
    started_d     = started_q | tick;
    snap_nums_d   = snap_nums_q;
    snap_dp_d     = snap_dp_q;
    snap_blink_d  = snap_blink_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start) begin
      snap_nums_d  = nums;
      snap_dp_d    = dp;
      snap_blink_d = blink_mask;
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Segment data looks at the snapshot as it will be after this edge, so the
  // first slot of a frame already shows the freshly captured digits.
  always_comb begin
    upper_zero = 1'b1;
    lz_mask    = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (snap_nums_d[4*i +: 4] == 4'd0);
      lz_mask[i] = upper_zero;
    end
    next_code = 4'd0;
    next_dp   = 1'b0;
    next_lz   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx_d) begin
        next_code = snap_nums_d[4*i +: 4];
        next_dp   = snap_dp_d[i];
        next_lz   = lz_mask[i];
      end
    end
    display_d = display_q;
    dp_out_d  = dp_out_q;
    if (tick) begin
      display_d = (lz_en && next_lz) ? 7'h7F : glyph(next_code, switchMode != 2'd0);
      dp_out_d  = ~next_dp;
    end
  end

  // Strobe follows idx/pwm by one clock; nothing lights before the first tick.
  always_comb begin
    cur_blink  = 1'b0;
    cur_strobe = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx_q) begin
        cur_blink     = snap_blink_q[i];
        cur_strobe[i] = 1'b0;
      end
    end
    lit     = started_q && (pwm_cnt_q <= brightness) && !(blink_phase_q && cur_blink);
    digit_d = lit ? cur_strobe : '1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_q    <= '0;
      idx_q         <= IDX_LAST;
      pwm_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      started_q     <= 1'b0;
      snap_nums_q   <= '0;
      snap_dp_q     <= '0;
      snap_blink_q  <= '0;
      display_q     <= 7'h7F;
      dp_out_q      <= 1'b1;
      digit_q       <= '1;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      pwm_cnt_q     <= pwm_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      started_q     <= started_d;
      snap_nums_q   <= snap_nums_d;
      snap_dp_q     <= snap_dp_d;
      snap_blink_q  <= snap_blink_d;
      display_q     <= display_d;
      dp_out_q      <= dp_out_d;
      digit_q       <= digit_d;
    end
  end

  assign display = display_q;
  assign dp_out  = dp_out_q;
  assign digit   = digit_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with DIGITS=4, SCAN_DIV=32, BLINK_FRAMES=2.
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] nums;
  logic [3:0]  dp;
  logic [3:0]  blink_mask;
  logic [3:0]  brightness;
  logic        lz_en;
  logic [1:0]  switchMode;
  logic [6:0]  display;
  logic        dp_out;
  logic [3:0]  digit;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  seven_segment_scanner #(.DIGITS(4), .SCAN_DIV(32), .BLINK_FRAMES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .nums       (nums),
    .dp         (dp),
    .blink_mask (blink_mask),
    .brightness (brightness),
    .lz_en      (lz_en),
    .switchMode (switchMode),
    .display    (display),
    .dp_out     (dp_out),
    .digit      (digit)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] n, input logic [3:0] d, input logic [3:0] bm,
                               input logic [3:0] br, input logic lz, input logic [1:0] sm);
    nums       = n;
    dp         = d;
    blink_mask = bm;
    brightness = br;
    lz_en      = lz;
    switchMode = sm;
  endtask

  // cyc counts rising edges since reset release; sampling happens 1 time unit after each edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    cyc += n;
  endtask

  task automatic next_slot();
    step(32 - (cyc % 32));
  endtask

  task automatic goto_frame();
    next_slot();
    while ((cyc / 32) % 4 != 1) next_slot();
  endtask

  task automatic show_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3, input logic [3:0] edp);
    logic [6:0] exp_seg [4];
    exp_seg[0] = e0;
    exp_seg[1] = e1;
    exp_seg[2] = e2;
    exp_seg[3] = e3;
    goto_frame();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_slot();
      checkOutput($sformatf("%s_seg%0d", tag, i), {25'd0, display}, {25'd0, exp_seg[i]});
      checkOutput($sformatf("%s_dp%0d", tag, i), {31'd0, dp_out}, {31'd0, ~edp[i]});
    end
  endtask

  task automatic measure_slot(input int idx, output int lit, output int bad);
    logic [3:0] strobe;
    strobe = ~(4'b0001 << idx);
    lit = 0;
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      step(1);
      if (digit == strobe) lit++;
      else if (digit != 4'hF) bad++;
    end
  endtask

  initial begin
    int lit;
    int bad;
    int dark_frames;
    int frame_no;
    bit dark;

    rst = 1'b0;
    applyStimulus(16'h1234, 4'b0000, 4'b0000, 4'd15, 1'b0, 2'd0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rst_display", {25'd0, display}, 32'h7F);
    checkOutput("rst_dp_out", {31'd0, dp_out}, 32'h1);
    checkOutput("rst_digit", {28'd0, digit}, 32'hF);
    rst = 1'b1;
    cyc = 0;

    bad = 0;
    for (int k = 0; k < 31; k++) begin
      step(1);
      if (digit != 4'hF) bad++;
    end
    checkOutput("pre_tick_dark", bad, 0);
    checkOutput("pre_tick_display", {25'd0, display}, 32'h7F);
    step(1);
    checkOutput("tick_digit_lag", {28'd0, digit}, 32'hF);
    checkOutput("first_slot_seg", {25'd0, display}, {25'd0, 7'b0011001});
    step(1);
    checkOutput("first_slot_strobe", {28'd0, digit}, {28'd0, 4'b1110});

    next_slot();
    checkOutput("slot1_seg", {25'd0, display}, {25'd0, 7'b0110000});
    step(1);
    checkOutput("slot1_strobe", {28'd0, digit}, {28'd0, 4'b1101});
    nums = 16'h5678;
    next_slot();
    checkOutput("coherent_slot2", {25'd0, display}, {25'd0, 7'b0100100});
    next_slot();
    checkOutput("coherent_slot3", {25'd0, display}, {25'd0, 7'b1111001});
    next_slot();
    checkOutput("new_frame_slot0", {25'd0, display}, {25'd0, 7'b0000000});

    applyStimulus(16'h9F9F, 4'b0000, 4'b0000, 4'd15, 1'b0, 2'd0);
    show_frame("auto", 7'b0101111, 7'b0010000, 7'b0101111, 7'b0010000, 4'b0000);
    applyStimulus(16'h9F9F, 4'b1010, 4'b0000, 4'd15, 1'b0, 2'd1);
    show_frame("manual", 7'b1111111, 7'b0101011, 7'b1111111, 7'b0101011, 4'b1010);

    applyStimulus(16'h0040, 4'b0100, 4'b0000, 4'd15, 1'b1, 2'd0);
    show_frame("lz_on", 7'b1000000, 7'b0011001, 7'h7F, 7'h7F, 4'b0100);
    applyStimulus(16'h0000, 4'b0000, 4'b0000, 4'd15, 1'b1, 2'd0);
    show_frame("lz_all0", 7'b1000000, 7'h7F, 7'h7F, 7'h7F, 4'b0000);
    applyStimulus(16'h0040, 4'b0000, 4'b0000, 4'd15, 1'b0, 2'd0);
    show_frame("lz_off", 7'b1000000, 7'b0011001, 7'b1000000, 7'b1000000, 4'b0000);

    goto_frame();
    brightness = 4'd3;
    measure_slot(0, lit, bad);
    checkOutput("pwm_b3_lit", lit, 8);
    checkOutput("pwm_b3_bad", bad, 0);
    brightness = 4'd0;
    measure_slot(1, lit, bad);
    checkOutput("pwm_b0_lit", lit, 2);
    brightness = 4'd15;
    measure_slot(2, lit, bad);
    checkOutput("pwm_b15_lit", lit, 32);
    brightness = 4'd7;
    measure_slot(3, lit, bad);
    checkOutput("pwm_b7_lit", lit, 16);

    // Blink phase is on during frames numbered 2,3 (mod 4) counting from reset.
    applyStimulus(16'h1234, 4'b0000, 4'b0010, 4'd15, 1'b0, 2'd0);
    dark_frames = 0;
    for (int f = 0; f < 4; f++) begin
      goto_frame();
      frame_no = (cyc - 32) / 128 + 1;
      dark = ((frame_no % 4) == 2) || ((frame_no % 4) == 3);
      measure_slot(0, lit, bad);
      checkOutput($sformatf("blink_d0_f%0d", f), lit, 32);
      measure_slot(1, lit, bad);
      checkOutput($sformatf("blink_d1_f%0d", f), lit, dark ? 0 : 32);
      checkOutput($sformatf("blink_d1_bad_f%0d", f), bad, 0);
      if (lit == 0) dark_frames++;
    end
    checkOutput("blink_dark_frames", dark_frames, 2);

    step(5);
    rst = 1'b0;
    #1;
    checkOutput("midrst_display", {25'd0, display}, 32'h7F);
    checkOutput("midrst_dp_out", {31'd0, dp_out}, 32'h1);
    checkOutput("midrst_digit", {28'd0, digit}, 32'hF);
    applyStimulus(16'h000C, 4'b0001, 4'b0000, 4'd15, 1'b0, 2'd0);
    step(3);
    rst = 1'b1;
    cyc = 0;
    step(31);
    checkOutput("restart_dark", {28'd0, digit}, 32'hF);
    checkOutput("restart_display", {25'd0, display}, 32'h7F);
    step(1);
    checkOutput("restart_seg", {25'd0, display}, {25'd0, 7'b0100001});
    checkOutput("restart_dp", {31'd0, dp_out}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
